// File: rtl/multicycle_ctrl_if.sv
// Control-side bundle between multicycle_ctrl and the 16-bit MIPS-like datapath.
// The controller drives the master modport; the datapath/memory side uses slave.
interface multicycle_ctrl_if;
  // memready: the memory asserts it in the cycle an access completes; the
  // controller keeps its strobe and address select steady until that cycle.
  logic [3:0]  opcode;
  logic [1:0]  funct;
  logic        zerosignal;
  logic        memready;
  logic [1:0]  ALUctrl;
  logic        alusrca;
  logic [1:0]  alusrcb;
  logic        pcwrite;
  logic [1:0]  pcsrc;
  logic        iord;
  logic        memread;
  logic        memwrite;
  logic        irwrite;
  logic        regwrite;
  logic        regdst;
  logic        memtoreg;
  logic        halted;
  logic [15:0] instcount;

  modport master (
    input  opcode, funct, zerosignal, memready,
    output ALUctrl, alusrca, alusrcb, pcwrite, pcsrc, iord, memread, memwrite,
           irwrite, regwrite, regdst, memtoreg, halted, instcount
  );

  modport slave (
    output opcode, funct, zerosignal, memready,
    input  ALUctrl, alusrca, alusrcb, pcwrite, pcsrc, iord, memread, memwrite,
           irwrite, regwrite, regdst, memtoreg, halted, instcount
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: fetch/decode/execute/memory/writeback FSM.
// Define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes in a sticky HALT state.
module multicycle_ctrl (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_ctrl_if.master       bus,
  output logic [3:0]              dbg_state
);

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_ANDI = 4'h2;
  localparam logic [3:0] OP_ORI  = 4'h3;
  localparam logic [3:0] OP_LW   = 4'h4;
  localparam logic [3:0] OP_SW   = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_BNE  = 4'h7;
  localparam logic [3:0] OP_J    = 4'h8;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_EXEC_I    = 4'd4,
    S_WB_ALU    = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_WB_MEM    = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
`ifdef CTRL_ILLEGAL_TRAP_EN
    , S_HALT    = 4'd12
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q;
  logic [15:0] instcount_q;
  logic        retire;

  assign dbg_state     = state_q;
  assign bus.instcount = instcount_q;

  // State register, opcode latch and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= 4'h0;
      instcount_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= bus.opcode;
      if (retire) instcount_q <= instcount_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = S_FETCH;
      S_FETCH:     if (bus.memready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_R:                    state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_EXEC_I;
          OP_LW, OP_SW:            state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:          state_d = S_BRANCH;
          OP_J:                    state_d = S_JUMP;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:                 state_d = S_HALT;
`else
          default:                 state_d = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_MEM_ADDR:  state_d = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (bus.memready) state_d = S_WB_MEM;
      S_MEM_WRITE: if (bus.memready) state_d = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_HALT:      state_d = S_HALT;
`endif
      default:     state_d = S_IDLE;
    endcase
  end

  // Moore decode, except memready gating in FETCH and the BRANCH pcwrite
  always_comb begin
    bus.ALUctrl  = 2'b00;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcwrite  = 1'b0;
    bus.pcsrc    = 2'b00;
    bus.iord     = 1'b0;
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.regwrite = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.halted   = 1'b0;
    retire       = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.memread = 1'b1;
        bus.alusrcb = 2'b01;
        bus.irwrite = bus.memready;
        bus.pcwrite = bus.memready;
      end
      S_DECODE: begin
        bus.alusrcb = 2'b11;
`ifndef CTRL_ILLEGAL_TRAP_EN
        // An illegal opcode retires here as a NOP
        retire = (bus.opcode > OP_J);
`endif
      end
      S_EXEC_R: begin
        bus.alusrca = 1'b1;
        bus.ALUctrl = bus.funct;
      end
      S_EXEC_I: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        case (op_q)
          OP_ANDI: bus.ALUctrl = 2'b10;
          OP_ORI:  bus.ALUctrl = 2'b11;
          default: bus.ALUctrl = 2'b00;
        endcase
      end
      S_WB_ALU: begin
        bus.regwrite = 1'b1;
        bus.regdst   = (op_q == OP_R);
        retire       = 1'b1;
      end
      S_MEM_ADDR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      S_MEM_READ: begin
        bus.memread = 1'b1;
        bus.iord    = 1'b1;
      end
      S_MEM_WRITE: begin
        bus.memwrite = 1'b1;
        bus.iord     = 1'b1;
        retire       = bus.memready;
      end
      S_WB_MEM: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
        retire       = 1'b1;
      end
      S_BRANCH: begin
        bus.alusrca = 1'b1;
        bus.ALUctrl = 2'b01;
        bus.pcsrc   = 2'b01;
        bus.pcwrite = (op_q == OP_BNE) ? ~bus.zerosignal : bus.zerosignal;
        retire      = 1'b1;
      end
      S_JUMP: begin
        bus.pcsrc   = 2'b10;
        bus.pcwrite = 1'b1;
        retire      = 1'b1;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_HALT: bus.halted = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule
